// File: rtl/wb_mtimer.sv
// wb_mtimer: Wishbone B4 classic responder implementing a RISC-V machine timer.
// 64-bit free-running mtime with a programmable prescaler, 64-bit mtimecmp and a
// registered level interrupt (mtime >= mtimecmp).
//
// Optional feature macro: WB_MTIMER_ERR_EN
//   defined   : requests to word addresses 6/7 answer with wb_err_o, no state change.
//   undefined : wb_err_o tied 0; addresses 6/7 acknowledge, read 0, writes dropped.
//
// Register map (word address):
//   0 MTIME_LO   1 MTIME_HI (reads the shadow latched by the last MTIME_LO read)
//   2 MTIMECMP_LO 3 MTIMECMP_HI
//   4 CTRL  bit0 EN, bits [8+PRESC_W-1:8] PRESC
//   5 STATUS bit0 irq_o (read-only)
module wb_mtimer #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [2:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        irq_o
);

  typedef enum logic [2:0] {
    ADR_MTIME_LO    = 3'd0,
    ADR_MTIME_HI    = 3'd1,
    ADR_MTIMECMP_LO = 3'd2,
    ADR_MTIMECMP_HI = 3'd3,
    ADR_CTRL        = 3'd4,
    ADR_STATUS      = 3'd5
  } reg_adr_e;

  // Apply a byte-enable mask: selected bytes take the bus value.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  // State
  logic [63:0]        mtime_q,    mtime_d;
  logic [63:0]        mtimecmp_q, mtimecmp_d;
  logic [31:0]        shadow_q,   shadow_d;
  logic [PRESC_W-1:0] pcnt_q,     pcnt_d;
  logic [PRESC_W-1:0] presc_q,    presc_d;
  logic               en_q,       en_d;
  logic               ack_q;
  logic [31:0]        dat_q;
  logic               irq_q;
  logic               err_q;

  // Bus decode
  logic        req;
  logic        bad_req;
  logic        acc_req;
  logic        wr;
  logic        rd;
  logic        tick;
  logic        mtime_wr;
  logic [31:0] ctrl_rd;
  logic [31:0] ctrl_new;
  logic [31:0] rd_data;

  // A new request is only taken when no acknowledge is in flight, which gives
  // the one-wait-state, one-cycle-pulse handshake.
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;

`ifdef WB_MTIMER_ERR_EN
  assign bad_req = req & (wb_adr_i[2:1] == 2'b11);
`else
  assign bad_req = 1'b0;
`endif

  assign acc_req  = req & ~bad_req;
  assign wr       = acc_req & wb_we_i;
  assign rd       = acc_req & ~wb_we_i;
  assign mtime_wr = wr & ((wb_adr_i == ADR_MTIME_LO) | (wb_adr_i == ADR_MTIME_HI));
  assign tick     = en_q & (pcnt_q == presc_q);

  // CTRL register image as seen on the bus.
  always_comb begin
    ctrl_rd               = '0;
    ctrl_rd[0]            = en_q;
    ctrl_rd[8 +: PRESC_W] = presc_q;
  end

  // Read mux: returns register state before the acknowledging edge.
  always_comb begin
    rd_data = '0;
    unique case (wb_adr_i)
      ADR_MTIME_LO:    rd_data = mtime_q[31:0];
      ADR_MTIME_HI:    rd_data = shadow_q;
      ADR_MTIMECMP_LO: rd_data = mtimecmp_q[31:0];
      ADR_MTIMECMP_HI: rd_data = mtimecmp_q[63:32];
      ADR_CTRL:        rd_data = ctrl_rd;
      ADR_STATUS:      rd_data = {31'd0, irq_q};
      default:         rd_data = '0;
    endcase
  end

  // Next-state logic for timer, compare, control and shadow registers.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    shadow_d   = shadow_q;
    pcnt_d     = pcnt_q;
    presc_d    = presc_q;
    en_d       = en_q;
    ctrl_new   = byte_merge(ctrl_rd, wb_dat_i, wb_sel_i);

    // Prescaler and counter; a bus write to mtime wins over the increment.
    if (en_q) begin
      pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
    end
    if (tick && !mtime_wr) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr) begin
      unique case (wb_adr_i)
        ADR_MTIME_LO:    mtime_d[31:0]     = byte_merge(mtime_q[31:0],     wb_dat_i, wb_sel_i);
        ADR_MTIME_HI:    mtime_d[63:32]    = byte_merge(mtime_q[63:32],    wb_dat_i, wb_sel_i);
        ADR_MTIMECMP_LO: mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0],  wb_dat_i, wb_sel_i);
        ADR_MTIMECMP_HI: mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], wb_dat_i, wb_sel_i);
        ADR_CTRL: begin
          en_d    = ctrl_new[0];
          presc_d = ctrl_new[8 +: PRESC_W];
          pcnt_d  = '0;
        end
        default: ;
      endcase
    end

    // Reading the low word freezes the high word for a coherent 64-bit read.
    if (rd && (wb_adr_i == ADR_MTIME_LO)) begin
      shadow_d = mtime_q[63:32];
    end
  end

  // Register update with asynchronous active-high reset.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values computed by the combinational block above.
    if (wb_rst_i) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      shadow_q   <= '0;
      pcnt_q     <= '0;
      presc_q    <= '0;
      en_q       <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      shadow_q   <= shadow_d;
      pcnt_q     <= pcnt_d;
      presc_q    <= presc_d;
      en_q       <= en_d;
      ack_q      <= acc_req;
      dat_q      <= rd ? rd_data : '0;
      irq_q      <= (mtime_q >= mtimecmp_q);
    end
  end

`ifdef WB_MTIMER_ERR_EN
  // Error acknowledge for unmapped addresses.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= bad_req;
    end
  end
`else
  assign err_q = 1'b0;
`endif

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_mtimer.sv
// Directed testbench for wb_mtimer with hand-computed expected values.
module tb_wb_mtimer;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [2:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        irq_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Result of the most recent bus transfer.
  int          last_lat;
  logic        last_tail;
  logic        last_err;
  logic        last_ack;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_mtimer #(.PRESC_W(8)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .irq_o    (irq_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One bus transfer; called #1 after a rising edge, returns #1 after the edge
  // following the acknowledge with the bus idle.
  task automatic xfer(input logic [2:0] adr, input logic we, input logic [31:0] wdat,
                      input logic [3:0] sel, output logic [31:0] rdat);
    wb_adr_i = adr;
    wb_we_i  = we;
    wb_dat_i = wdat;
    wb_sel_i = sel;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    last_lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge wb_clk_i); #1;
      if (wb_ack_o || wb_err_o) begin
        last_lat = i;
        break;
      end
    end
    if (last_lat == 0) check("ack_timeout", 64'd0, 64'd1);
    rdat     = wb_dat_o;
    last_err = wb_err_o;
    last_ack = wb_ack_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_sel_i = 4'h0;
    @(posedge wb_clk_i); #1;
    last_tail = wb_ack_o | wb_err_o;
  endtask

  task automatic wr(input logic [2:0] adr, input logic [31:0] wdat, input logic [3:0] sel);
    logic [31:0] unused_rd;
    xfer(adr, 1'b1, wdat, sel, unused_rd);
  endtask

  task automatic rd(input logic [2:0] adr, output logic [31:0] rdat);
    xfer(adr, 1'b0, 32'd0, 4'h0, rdat);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] lo;
    int          rise;
    logic        seen_ack;

    wb_rst_i = 1'b1;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_sel_i = '0;
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("rst_ack", wb_ack_o, 0);
    check("rst_err", wb_err_o, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_irq", irq_o, 0);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;

    // Reset values of every register, plus handshake shape.
    rd(3'd0, d); check("rst_mtime_lo", d, 32'h0);
    check("ack_latency", last_lat, 1);
    check("ack_width", last_tail, 0);
    rd(3'd1, d); check("rst_mtime_hi", d, 32'h0);
    rd(3'd2, d); check("rst_cmp_lo", d, 32'hFFFF_FFFF);
    check("dat_idle_zero", wb_dat_o, 0);
    rd(3'd3, d); check("rst_cmp_hi", d, 32'hFFFF_FFFF);
    rd(3'd4, d); check("rst_ctrl", d, 32'h0);
    rd(3'd5, d); check("rst_status", d, 32'h0);

    // Prescaler 3: one tick per 4 cycles, about 10 ticks over 40 cycles.
    wr(3'd4, 32'h0000_0301, 4'hF);
    rd(3'd4, d); check("ctrl_readback", d, 32'h0000_0301);
    repeat (40) @(posedge wb_clk_i);
    #1;
    rd(3'd0, d); check("mtime_presc3", (d >= 32'd9) && (d <= 32'd11), 1);

    // Carry across bit 32 with coherent high-word read.
    wr(3'd4, 32'h0, 4'hF);
    wr(3'd0, 32'hFFFF_FFFE, 4'hF);
    wr(3'd1, 32'h0, 4'hF);
    wr(3'd4, 32'h0000_0001, 4'hF);
    rd(3'd0, lo); check("carry_lo", lo, 32'hFFFF_FFFF);
    repeat (5) @(posedge wb_clk_i);
    #1;
    rd(3'd1, d); check("carry_hi_shadow", d, 32'h0);
    rd(3'd0, lo);
    rd(3'd1, d); check("carry_hi_after", d, 32'h1);

    // Compare interrupt: irq one cycle after mtime reaches 20.
    wr(3'd4, 32'h0, 4'hF);
    wr(3'd0, 32'h0, 4'hF);
    wr(3'd1, 32'h0, 4'hF);
    wr(3'd3, 32'h0, 4'hF);
    wr(3'd2, 32'd20, 4'hF);
    check("irq_low_before", irq_o, 0);
    wr(3'd4, 32'h0000_0001, 4'hF);
    check("irq_low_start", irq_o, 0);
    rise = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge wb_clk_i); #1;
      if (irq_o) begin
        rise = n;
        break;
      end
    end
    check("irq_rise_cycle", rise, 20);
    rd(3'd5, d); check("status_irq", d, 32'h1);
    wr(3'd3, 32'h1, 4'hF);
    check("irq_cleared", irq_o, 0);

    // Reset asserted while a CTRL write is pending: no ack, nothing commits.
    wr(3'd4, 32'h0, 4'hF);
    wb_adr_i = 3'd4;
    wb_we_i  = 1'b1;
    wb_dat_i = 32'h0000_0301;
    wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    #2 wb_rst_i = 1'b1;
    seen_ack = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge wb_clk_i); #1;
      seen_ack = seen_ack | wb_ack_o;
    end
    check("rst_mid_no_ack", seen_ack, 0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    rd(3'd4, d); check("rst_mid_ctrl", d, 32'h0);
    rd(3'd3, d); check("rst_mid_cmp_hi", d, 32'hFFFF_FFFF);

    // Byte-granular writes.
    wr(3'd2, 32'h0000_00AA, 4'b0001);
    rd(3'd2, d); check("cmp_lo_byte", d, 32'hFFFF_FFAA);
    wr(3'd4, 32'h0000_0500, 4'b0010);
    rd(3'd4, d); check("ctrl_byte1", d, 32'h0000_0500);
    wr(3'd4, 32'h0, 4'hF);

    // Unmapped address 7.
    wr(3'd7, 32'hDEAD_BEEF, 4'hF);
`ifdef WB_MTIMER_ERR_EN
    check("adr7_wr_err", last_err, 1);
    check("adr7_wr_ack", last_ack, 0);
`else
    check("adr7_wr_ack", last_ack, 1);
    check("adr7_wr_err", last_err, 0);
`endif
    rd(3'd7, d); check("adr7_rd_data", d, 32'h0);
`ifdef WB_MTIMER_ERR_EN
    check("adr7_rd_err", last_err, 1);
`else
    check("adr7_rd_ack", last_ack, 1);
`endif
    rd(3'd2, d); check("adr7_keep_cmp_lo", d, 32'hFFFF_FFAA);
    rd(3'd3, d); check("adr7_keep_cmp_hi", d, 32'hFFFF_FFFF);
    rd(3'd4, d); check("adr7_keep_ctrl", d, 32'h0);
    rd(3'd0, d); check("adr7_keep_mtime", d, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_mtimer.md
# wb_mtimer

Wishbone B4 classic responder giving the SoC a RISC-V machine timer: a 64-bit free-running `mtime` counter with a programmable prescaler, a 64-bit `mtimecmp` compare register, and a level timer interrupt. It sits on the shared interconnect next to the boot ROM and UART. Its slave port answers the CPU data master, and `irq_o` feeds the core's machine timer interrupt input.

## Interface
- `PRESC_W`, default 8: prescaler field and counter width, 1..16.
- `wb_clk_i  in  1`: clock. All state changes on its rising edge.
- `wb_rst_i  in  1`: reset. Asynchronous, active-high.
- `wb_adr_i  in  3`: word address; the integrator connects byte-address bits [4:2].
- `wb_dat_i  in  32`: write data.
- `wb_sel_i  in  4`: byte enables for writes.
- `wb_we_i  in  1`: write strobe qualifier.
- `wb_cyc_i  in  1`: bus cycle.
- `wb_stb_i  in  1`: strobe.
- `wb_dat_o  out  32`: read data. Valid only while `wb_ack_o` is high; 0 otherwise.
- `wb_ack_o  out  1`: transfer acknowledge.
- `wb_err_o  out  1`: error acknowledge; see Configuration.
- `irq_o  out  1`: timer interrupt, level.

## Operation
- Register map (`wb_adr_i`):
  - 0: MTIME_LO.
  - 1: MTIME_HI.
  - 2: MTIMECMP_LO.
  - 3: MTIMECMP_HI.
  - 4: CTRL. Bit 0 EN; bits [8+PRESC_W-1:8] PRESC; all other bits read 0.
  - 5: STATUS. Read-only; bit 0 = `irq_o`.
  - 6, 7: unmapped.
- Writes are byte-granular per `wb_sel_i`. Writes to STATUS are ignored.
- Prescaler: counter `pcnt` counts only while EN=1.
  - When `pcnt == PRESC`, the cycle is a tick: `pcnt` returns to 0 and `mtime` increments by 1, wrapping modulo 2^64.
  - PRESC=0 gives a tick every cycle.
  - EN=0 holds both `pcnt` and `mtime`.
  - Any write to CTRL clears `pcnt`.
- Write to MTIME_LO or MTIME_HI in a tick cycle: the written bytes take the bus value and the increment is suppressed for that cycle. `pcnt` still wraps.
- Read coherency: reading MTIME_LO also latches current MTIME_HI into a shadow register. Reading MTIME_HI returns the shadow, not the live value.
- `irq_o` is registered: (`mtime` >= `mtimecmp`), 64-bit unsigned, evaluated every cycle regardless of EN.

## Timing
- Reset values:
  - `mtime` = 0, shadow = 0, `pcnt` = 0, CTRL = 0.
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
  - `wb_ack_o` = 0, `wb_err_o` = 0, `wb_dat_o` = 0, `irq_o` = 0.
- Handshake: a request is `wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o` sampled on a clock edge.
  - `wb_ack_o` (or `wb_err_o`) is high for exactly the following cycle: one wait state, one-cycle pulse.
  - A master holding `stb` gets an acknowledge every second cycle.
- Write commit: register contents update on the same edge that raises `wb_ack_o`.
- Read data: `wb_dat_o` is registered alongside `wb_ack_o` and reflects register state before that edge.
- `irq_o` latency: one cycle after `mtime`/`mtimecmp` reach their new values. A `mtimecmp` write therefore affects `irq_o` two edges after the request is sampled.
- Dropped request: a request sampled and then withdrawn still produces its acknowledge pulse, and the write still commits.
- Reset asserted mid-transfer: all state clears immediately and no acknowledge is issued for the pending request.

## Configuration
- `WB_MTIMER_ERR_EN` defined:
  - A request to address 6 or 7 returns a `wb_err_o` pulse instead of `wb_ack_o`.
  - `wb_dat_o` stays 0; no state changes.
- `WB_MTIMER_ERR_EN` undefined:
  - `wb_err_o` is tied 0.
  - Unmapped reads acknowledge with data 0; unmapped writes acknowledge and are discarded.

## Test plan
- Reset release, then read every register. Required: MTIME 0; MTIMECMP 0xFFFFFFFF both halves; CTRL 0; STATUS 0; each `wb_ack_o` exactly one cycle, one wait state after `stb`.
- Write CTRL=0x00000301 (EN=1, PRESC=3) and wait 40 cycles. Required: `mtime` advances 1 per 4 cycles; MTIME_LO reads 10 (±1 for read timing).
- Write MTIME_LO=0xFFFFFFFE, MTIME_HI=0, PRESC=0, EN=1, and let it run across the carry. Then read LO, wait 5 cycles, read HI. Required: HI equals the value latched at the LO read (0 or 1, coherent with LO), not the live value.
- Write MTIMECMP_HI=0 then MTIMECMP_LO=20, with `mtime` counting from 0 and PRESC=0. Required: `irq_o` rises exactly one cycle after `mtime` reaches 20; writing MTIMECMP_HI=1 lowers it.
- Write MTIMECMP_LO=0x000000AA with `wb_sel_i`=4'b0001 over the reset value. Required: readback 0xFFFFFFAA.
- Access address 7 with and without `WB_MTIMER_ERR_EN`. Required: an `err` pulse with no `ack` (macro defined), or an `ack` with data 0 (macro undefined); no register modified either way.
